rv32_io_ctrl: RTL and testbench

RV32_IO_CTRL -- requirements
Module: rv32_io_ctrl

---
 rtl/rv32_io_pkg.sv | 30 +++
 rtl/io_debounce.sv | 48 ++++
 rtl/rv32_io_ctrl.sv | 123 ++++++++++++
 tb/tb_rv32_io_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rv32_io_pkg.sv
// Shared constants for the rv32 I/O controller: register word offsets,
// the IRQ_EN bit that gates the timer interrupt, and reset values.
package rv32_io_pkg;

  localparam logic [2:0] OFF_LED_DATA  = 3'd0;
  localparam logic [2:0] OFF_KEY_STATE = 3'd1;
  localparam logic [2:0] OFF_KEY_EDGE  = 3'd2;
  localparam logic [2:0] OFF_IRQ_EN    = 3'd3;
  localparam logic [2:0] OFF_TIMER_CNT = 3'd4;
  localparam logic [2:0] OFF_TIMER_CMP = 3'd5;
  localparam logic [2:0] OFF_STATUS    = 3'd6;

  // IRQ_EN holds one enable per key in the low byte plus the timer enable.
  localparam int          IRQ_TIMER_BIT = 8;
  localparam int          IRQ_EN_W      = IRQ_TIMER_BIT + 1;
  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  // Merge new_val into old_val one byte lane at a time under byte enables.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) res[8*n +: 8] = new_val[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One push key: 2-flop synchroniser followed by a stable-count debouncer.
// key_rise pulses in the same cycle the debounced level is updated 0->1.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_rise
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key level into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= key_raw;
      sync1 <= sync0;
    end
  end

  // Count cycles of disagreement; accept the new level once it has held long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      key_level <= 1'b0;
    end else if (sync1 == key_level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt       <= '0;
      key_level <= sync1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign key_rise = (sync1 != key_level) && (cnt == CNT_MAX) && sync1;

endmodule

// File: rtl/rv32_io_ctrl.sv
// Memory-mapped LED / push-key / timer block for a small RV32 core.
// Bus protocol: there is no ready; a write is accepted in every cycle io_we
// is high, and io_rdata always reflects the address presented one cycle earlier.
module rv32_io_ctrl
  import rv32_io_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_LEDS        = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         io_addr,
  input  logic                io_we,
  input  logic [3:0]          io_be,
  input  logic [31:0]         io_wdata,
  output logic [31:0]         io_rdata,
  input  logic [NUM_KEYS-1:0] PUSH_KEY,
  output logic [NUM_LEDS-1:0] LEDS,
  output logic                irq
);

  logic [NUM_LEDS-1:0] led_data;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_edge;
  logic [IRQ_EN_W-1:0] irq_en;
  logic [31:0]         timer_cnt;
  logic [31:0]         timer_cmp;
  logic                status;

  logic [2:0]  word_off;
  logic [31:0] w1c_mask;
  logic [31:0] rdata_next;
  logic        unused_addr_bits;

  assign word_off         = io_addr[4:2];
  assign unused_addr_bits = ^{io_addr[31:5], io_addr[1:0]};
  assign w1c_mask         = be_merge(32'h0, io_wdata, io_be);
  assign LEDS             = led_data;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (PUSH_KEY[k]),
      .key_level(key_level[k]),
      .key_rise (key_rise[k])
    );
  end

  // Read mux over current register values, zero-extended.
  always_comb begin
    rdata_next = 32'h0;
    case (word_off)
      OFF_LED_DATA:  rdata_next = 32'(led_data);
      OFF_KEY_STATE: rdata_next = 32'(key_level);
      OFF_KEY_EDGE:  rdata_next = 32'(key_edge);
      OFF_IRQ_EN:    rdata_next = 32'(irq_en);
      OFF_TIMER_CNT: rdata_next = timer_cnt;
      OFF_TIMER_CMP: rdata_next = timer_cmp;
      OFF_STATUS:    rdata_next = 32'(status);
      default:       rdata_next = 32'h0;
    endcase
  end

  // Registered read data, one cycle behind the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) io_rdata <= 32'h0;
    else       io_rdata <= rdata_next;
  end

  // Plain read/write registers: LED_DATA, IRQ_EN, TIMER_CMP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_data  <= '0;
      irq_en    <= '0;
      timer_cmp <= TIMER_CMP_RST;
    end else if (io_we) begin
      if (word_off == OFF_LED_DATA)
        led_data <= NUM_LEDS'(be_merge(32'(led_data), io_wdata, io_be));
      if (word_off == OFF_IRQ_EN)
        irq_en <= IRQ_EN_W'(be_merge(32'(irq_en), io_wdata, io_be));
      if (word_off == OFF_TIMER_CMP)
        timer_cmp <= be_merge(timer_cmp, io_wdata, io_be);
    end
  end

  // Free-running timer; a write replaces the increment for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer_cnt <= 32'h0;
    else if (io_we && word_off == OFF_TIMER_CNT)
      timer_cnt <= be_merge(timer_cnt, io_wdata, io_be);
    else
      timer_cnt <= timer_cnt + 32'd1;
  end

  // Sticky key press edges and timer match; a new event beats a W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_edge <= '0;
      status   <= 1'b0;
    end else begin
      if (io_we && word_off == OFF_KEY_EDGE)
        key_edge <= (key_edge & ~w1c_mask[NUM_KEYS-1:0]) | key_rise;
      else
        key_edge <= key_edge | key_rise;
      if (timer_cnt == timer_cmp)
        status <= 1'b1;
      else if (io_we && word_off == OFF_STATUS && w1c_mask[0])
        status <= 1'b0;
    end
  end

  // Registered interrupt request from enabled sticky sources.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (|(key_edge & irq_en[NUM_KEYS-1:0])) |
                      (status & irq_en[IRQ_TIMER_BIT]);
  end

endmodule

// File: tb/tb_rv32_io_ctrl.sv
// Bench for rv32_io_ctrl with a short debounce window.
module tb_rv32_io_ctrl;

  localparam int NUM_KEYS = 2;
  localparam int NUM_LEDS = 10;
  localparam int DEB      = 4;

  logic                clk;
  logic                reset;
  logic [31:0]         io_addr;
  logic                io_we;
  logic [3:0]          io_be;
  logic [31:0]         io_wdata;
  logic [31:0]         io_rdata;
  logic [NUM_KEYS-1:0] PUSH_KEY;
  logic [NUM_LEDS-1:0] LEDS;
  logic                irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  rv32_io_ctrl #(
    .NUM_KEYS(NUM_KEYS), .NUM_LEDS(NUM_LEDS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_we(io_we), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .PUSH_KEY(PUSH_KEY),
    .LEDS(LEDS), .irq(irq)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=0x%08h req=0x%08h", tag, act, exp);
    end
  endtask

  // Drivers: called at a negedge, return at the following negedge.
  task automatic bus_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] be);
    io_addr  = {27'd0, off, 2'b00};
    io_wdata = data;
    io_be    = be;
    io_we    = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
    io_be = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] off, input logic [31:0] exp, input string tag);
    io_addr = {27'd0, off, 2'b00};
    io_we   = 1'b0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check_val(tag_q.pop_front(), io_rdata, exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b1; io_addr = '0; io_we = 1'b0; io_be = '0; io_wdata = '0; PUSH_KEY = '0;
    repeat (3) @(negedge clk);
    check_val("rst_leds", {22'd0, LEDS}, 32'h0);
    check_val("rst_irq", {31'd0, irq}, 32'h0);
    check_val("rst_rdata", io_rdata, 32'h0);
    reset = 1'b0;
    bus_read(3'd5, 32'hFFFF_FFFF, "rst_cmp");
    bus_read(3'd3, 32'h0, "rst_irq_en");

    // LED byte lanes
    bus_write(3'd0, 32'h0000_03A5, 4'b0001);
    check_val("led_be0", {22'd0, LEDS}, 32'h0A5);
    bus_write(3'd0, 32'h0000_0200, 4'b0010);
    check_val("led_be1", {22'd0, LEDS}, 32'h2A5);
    bus_read(3'd0, 32'h2A5, "led_read");

    // Glitch rejected
    io_addr = {27'd0, 3'd1, 2'b00};
    PUSH_KEY[0] = 1'b1;
    repeat (2) @(negedge clk);
    PUSH_KEY[0] = 1'b0;
    repeat (8) @(negedge clk);
    bus_read(3'd1, 32'h0, "glitch");

    // Stable press: KEY_STATE updates on the 6th edge, visible on read of the 7th
    PUSH_KEY[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back((k == 7) ? 32'h1 : 32'h0);
      tag_q.push_back($sformatf("deb_lat_%0d", k));
      @(negedge clk);
      check_val(tag_q.pop_front(), io_rdata, exp_q.pop_front());
    end
    bus_read(3'd2, 32'h1, "edge0_set");

    // Key 1 edge and irq
    PUSH_KEY[1] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(3'd2, 32'h3, "edge_both");
    check_val("irq_off", {31'd0, irq}, 32'h0);
    bus_write(3'd3, 32'h2, 4'hF);
    check_val("irq_lag", {31'd0, irq}, 32'h0);
    @(negedge clk);
    check_val("irq_on", {31'd0, irq}, 32'h1);
    bus_write(3'd2, 32'h2, 4'hF);
    check_val("irq_clr_lag", {31'd0, irq}, 32'h1);
    @(negedge clk);
    check_val("irq_clr", {31'd0, irq}, 32'h0);
    bus_read(3'd2, 32'h1, "edge1_clr");
    PUSH_KEY[1] = 1'b0;
    repeat (8) @(negedge clk);
    bus_read(3'd2, 32'h1, "release_no_edge");
    PUSH_KEY[1] = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(3'd2, 32'h2, 4'hF);
    bus_read(3'd2, 32'h3, "set_wins");
    check_val("irq_set_wins", {31'd0, irq}, 32'h1);

    // Timer wrap and match
    bus_write(3'd2, 32'h3, 4'hF);
    bus_write(3'd4, 32'hFFFF_FFFE, 4'hF);
    bus_write(3'd5, 32'h0000_0001, 4'hF);
    bus_write(3'd3, 32'h0000_0100, 4'hF);
    check_val("irq_tmr_idle", {31'd0, irq}, 32'h0);
    bus_read(3'd4, 32'h0, "timer_wrap");
    bus_read(3'd6, 32'h0, "status_pre");
    bus_read(3'd6, 32'h1, "status_match");
    check_val("irq_timer", {31'd0, irq}, 32'h1);
    bus_write(3'd6, 32'h1, 4'hF);
    bus_read(3'd6, 32'h0, "status_w1c");
    check_val("irq_timer_clr", {31'd0, irq}, 32'h0);

    // RO / unmapped, then reset mid-debounce
    PUSH_KEY = '0;
    repeat (8) @(negedge clk);
    bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd1, 32'h0, "key_state_ro");
    bus_read(3'd7, 32'h0, "unmapped");
    bus_read(3'd0, 32'h2A5, "led_pre_rst");
    PUSH_KEY[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("mid_rst_leds", {22'd0, LEDS}, 32'h0);
    check_val("mid_rst_rdata", io_rdata, 32'h0);
    check_val("mid_rst_irq", {31'd0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(3'd5, 32'hFFFF_FFFF, "cmp_after_rst");
    bus_read(3'd0, 32'h0, "led_after_rst");
    bus_read(3'd2, 32'h0, "edge_after_rst");
    bus_read(3'd1, 32'h0, "held_e4");
    bus_read(3'd1, 32'h0, "held_e5");
    bus_read(3'd1, 32'h0, "held_e6");
    bus_read(3'd1, 32'h1, "held_rise");
    bus_read(3'd2, 32'h1, "held_edge");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
